// File: rtl/cpu_ctrl.sv
// Microcode sequencer for the 4-bit SAP CPU: T-state counter, opcode decode, control word.
// Latency: ctrl is combinational from tstate/opcode/flags; tstate and halted update on posedge clk.
// Backpressure: run=0 freezes tstate/halted and forces ctrl=0; halted forces ctrl=0 until rst.
// Optional feature macro: CPU_CTRL_COND_JUMP_EN (JC/JZ conditional jumps; otherwise they run as NOP).
module cpu_ctrl #(
    parameter int T_LAST = 5    // highest legal T-state; must be >= 4 so ADD/SUB fit
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [13:0] ctrl,
    output logic [2:0]  tstate,
    output logic        halted
);

    // T-state encodings
    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    // Opcodes
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Control word bits
    localparam logic [13:0] PC_INC   = 14'h0001;
    localparam logic [13:0] PC_LOAD  = 14'h0002;
    localparam logic [13:0] PC_OUT   = 14'h0004;
    localparam logic [13:0] MAR_LOAD = 14'h0008;
    localparam logic [13:0] RAM_OUT  = 14'h0010;
    localparam logic [13:0] RAM_LOAD = 14'h0020;
    localparam logic [13:0] IR_LOAD  = 14'h0040;
    localparam logic [13:0] IR_OUT   = 14'h0080;
    localparam logic [13:0] A_LOAD   = 14'h0100;
    localparam logic [13:0] A_OUT    = 14'h0200;
    localparam logic [13:0] B_LOAD   = 14'h0400;
    localparam logic [13:0] ALU_OUT  = 14'h0800;
    localparam logic [13:0] ALU_SUB  = 14'h1000;
    localparam logic [13:0] OUT_LOAD = 14'h2000;

    logic [2:0]  tstate_q, tstate_d;
    logic        halted_q, halted_d;
    logic [13:0] ctrl_raw;
    logic        last_step;
    logic        wrap;
    logic        advance;

`ifndef CPU_CTRL_COND_JUMP_EN
    // Flags only matter for conditional jumps, which are absent in this build.
    logic unused_flags;
    assign unused_flags = flag_c ^ flag_z;
`endif

    // Microcode decode: strobes for the current step, and whether this step ends the instruction
    always_comb begin
        ctrl_raw  = '0;
        last_step = 1'b0;
        case (tstate_q)
            T0: ctrl_raw = PC_OUT | MAR_LOAD;
            T1: ctrl_raw = RAM_OUT | IR_LOAD | PC_INC;
            T2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl_raw = IR_OUT | MAR_LOAD;
                    OP_LDI: begin ctrl_raw = IR_OUT | A_LOAD;   last_step = 1'b1; end
                    OP_JMP: begin ctrl_raw = IR_OUT | PC_LOAD;  last_step = 1'b1; end
`ifdef CPU_CTRL_COND_JUMP_EN
                    OP_JC:  begin ctrl_raw = IR_OUT | (flag_c ? PC_LOAD : 14'h0000); last_step = 1'b1; end
                    OP_JZ:  begin ctrl_raw = IR_OUT | (flag_z ? PC_LOAD : 14'h0000); last_step = 1'b1; end
`endif
                    OP_OUT: begin ctrl_raw = A_OUT | OUT_LOAD;  last_step = 1'b1; end
                    // NOP, HLT, undefined opcodes (and JC/JZ when not built in)
                    default: last_step = 1'b1;
                endcase
            end
            T3: begin
                case (opcode)
                    OP_LDA:         begin ctrl_raw = RAM_OUT | A_LOAD; last_step = 1'b1; end
                    OP_ADD, OP_SUB: ctrl_raw = RAM_OUT | B_LOAD;
                    OP_STA:         begin ctrl_raw = A_OUT | RAM_LOAD; last_step = 1'b1; end
                    default:        last_step = 1'b1;
                endcase
            end
            T4: begin
                last_step = 1'b1;
                case (opcode)
                    OP_ADD:  ctrl_raw = ALU_OUT | A_LOAD;
                    OP_SUB:  ctrl_raw = ALU_OUT | A_LOAD | ALU_SUB;
                    default: ctrl_raw = '0;
                endcase
            end
            default: last_step = 1'b1;
        endcase
    end

    // Next-state: advance only while running and not halted; wrap to T0 at end of instruction
    always_comb begin
        advance  = run & ~halted_q;
        wrap     = (tstate_q >= 3'(T_LAST));
        tstate_d = tstate_q;
        halted_d = halted_q;
        if (advance) begin
            tstate_d = (last_step || wrap) ? T0 : tstate_q + 3'd1;
            if (tstate_q == T2 && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end
        end
    end

    // Sequencer state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tstate_q <= T0;
            halted_q <= 1'b0;
        end else begin
            tstate_q <= tstate_d;
            halted_q <= halted_d;
        end
    end

    // Outputs: strobes suppressed during reset, freeze and halt
    always_comb begin
        ctrl   = (advance && !rst) ? ctrl_raw : 14'h0000;
        tstate = tstate_q;
        halted = halted_q;
    end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed testbench for cpu_ctrl: fetch/execute strobes, cadence, reset, freeze, halt.
module tb_cpu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [3:0]  opcode;
    logic        flag_c;
    logic        flag_z;
    logic [13:0] ctrl;
    logic [2:0]  tstate;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    cpu_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .opcode (opcode),
        .flag_c (flag_c),
        .flag_z (flag_z),
        .ctrl   (ctrl),
        .tstate (tstate),
        .halted (halted)
    );

    always #5 clk = ~clk;

`ifdef CPU_CTRL_COND_JUMP_EN
    localparam logic [15:0] JTAKEN = 16'h0082;
    localparam logic [15:0] JNOT   = 16'h0080;
`else
    localparam logic [15:0] JTAKEN = 16'h0000;
    localparam logic [15:0] JNOT   = 16'h0000;
`endif

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle away from the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Run one full instruction from T0, checking ctrl and tstate each cycle
    task automatic run_instr(input string tag, input logic [3:0] op, input int n,
                             input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                             input logic [15:0] e3, input logic [15:0] e4);
        logic [15:0] exp_c [5];
        exp_c = '{e0, e1, e2, e3, e4};
        opcode = op;
        #1;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_t%0d_ts", tag, i), {13'd0, tstate}, 16'(i));
            check($sformatf("%s_t%0d_ctrl", tag, i), {2'b00, ctrl}, exp_c[i]);
            tick();
        end
        check($sformatf("%s_end_ts", tag), {13'd0, tstate}, 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; run = 1'b1; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
        tick(); tick();
        check("rst_ts",     {13'd0, tstate}, 16'd0);
        check("rst_halted", {15'd0, halted}, 16'd0);
        check("rst_ctrl",   {2'b00, ctrl},   16'h0000);
        rst = 1'b0;
        #1;
        check("rel_t0_ctrl", {2'b00, ctrl}, 16'h000C);

        // LDA then next instruction at T0
        run_instr("lda", 4'h1, 4, 16'h000C, 16'h0051, 16'h0088, 16'h0110, 16'h0000);

        // Three back-to-back SUBs: 5-cycle cadence
        for (int k = 0; k < 3; k++)
            run_instr($sformatf("sub%0d", k), 4'h3, 5, 16'h000C, 16'h0051, 16'h0088, 16'h0410, 16'h1900);
        run_instr("add", 4'h2, 5, 16'h000C, 16'h0051, 16'h0088, 16'h0410, 16'h0900);
        run_instr("sta", 4'h4, 4, 16'h000C, 16'h0051, 16'h0088, 16'h0220, 16'h0000);
        run_instr("ldi", 4'h5, 3, 16'h000C, 16'h0051, 16'h0180, 16'h0000, 16'h0000);
        run_instr("jmp", 4'h6, 3, 16'h000C, 16'h0051, 16'h0082, 16'h0000, 16'h0000);
        run_instr("out", 4'hE, 3, 16'h000C, 16'h0051, 16'h2200, 16'h0000, 16'h0000);
        run_instr("nop", 4'h0, 3, 16'h000C, 16'h0051, 16'h0000, 16'h0000, 16'h0000);
        run_instr("undef", 4'hB, 3, 16'h000C, 16'h0051, 16'h0000, 16'h0000, 16'h0000);

        // Conditional jumps
        flag_z = 1'b1;
        run_instr("jz_t", 4'h8, 3, 16'h000C, 16'h0051, JTAKEN, 16'h0000, 16'h0000);
        flag_z = 1'b0;
        run_instr("jz_n", 4'h8, 3, 16'h000C, 16'h0051, JNOT, 16'h0000, 16'h0000);
        flag_c = 1'b1;
        run_instr("jc_t", 4'h7, 3, 16'h000C, 16'h0051, JTAKEN, 16'h0000, 16'h0000);
        flag_c = 1'b0;
        run_instr("jc_n", 4'h7, 3, 16'h000C, 16'h0051, JNOT, 16'h0000, 16'h0000);

        // Async reset mid-T3 of ADD
        opcode = 4'h2;
        tick(); tick(); tick();
        check("add_mid_ts",   {13'd0, tstate}, 16'd3);
        check("add_mid_ctrl", {2'b00, ctrl},   16'h0410);
        rst = 1'b1;
        #1;
        check("arst_ts",     {13'd0, tstate}, 16'd0);
        check("arst_halted", {15'd0, halted}, 16'd0);
        check("arst_ctrl",   {2'b00, ctrl},   16'h0000);
        tick();
        rst = 1'b0;
        #1;
        check("arst_rel_ctrl", {2'b00, ctrl}, 16'h000C);

        // Freeze during T1 of LDA
        opcode = 4'h1;
        tick();
        run = 1'b0;
        #1;
        check("frz_ctrl0", {2'b00, ctrl}, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("frz%0d_ts", i),   {13'd0, tstate}, 16'd1);
            check($sformatf("frz%0d_ctrl", i), {2'b00, ctrl},   16'h0000);
        end
        run = 1'b1;
        #1;
        check("resume_ctrl", {2'b00, ctrl}, 16'h0051);
        tick();
        check("resume_ts", {13'd0, tstate}, 16'd2);
        check("resume_t2_ctrl", {2'b00, ctrl}, 16'h0088);
        tick(); tick();
        check("resume_end_ts", {13'd0, tstate}, 16'd0);

        // HLT
        opcode = 4'hF;
        tick(); tick();
        check("hlt_t2_ts",     {13'd0, tstate}, 16'd2);
        check("hlt_t2_ctrl",   {2'b00, ctrl},   16'h0000);
        check("hlt_pre",       {15'd0, halted}, 16'd0);
        tick();
        check("hlt_set",       {15'd0, halted}, 16'd1);
        for (int i = 0; i < 20; i++) begin
            opcode = 4'(i);
            tick();
            check($sformatf("hlt%0d_ctrl", i),   {2'b00, ctrl},   16'h0000);
            check($sformatf("hlt%0d_ts", i),     {13'd0, tstate}, 16'd0);
            check($sformatf("hlt%0d_halted", i), {15'd0, halted}, 16'd1);
        end
        rst = 1'b1;
        #1;
        check("hlt_clr", {15'd0, halted}, 16'd0);
        tick();
        rst = 1'b0;
        opcode = 4'h5;
        #1;
        check("hlt_rel_ctrl", {2'b00, ctrl}, 16'h000C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
